// File: rtl/cache_fill_fsm.sv
// Cache block fill controller.
// Streams one block from multi-cycle memory into the cache data/tag arrays.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [15:0]       memory_data,
  output logic              fsm_busy,
  output logic              memory_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] data_array_address,
  output logic [15:0]       data_array_data,
  output logic              write_tag_array
);

  localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK =
    ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  req_cnt;
  logic [CNT_W-1:0]  rcv_cnt;
  logic              req_done;
  logic [ADDR_W-1:0] req_off;
  logic [ADDR_W-1:0] rcv_off;
  logic              last_word;

  assign req_off   = ADDR_W'({req_cnt, 1'b0});
  assign rcv_off   = ADDR_W'({rcv_cnt, 1'b0});
  assign last_word = memory_data_valid && (rcv_cnt == LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state and outputs; IDLE outputs never look at miss_detected
  always_comb begin
    state_d            = state;
    fsm_busy           = 1'b0;
    memory_read        = 1'b0;
    memory_address     = '0;
    write_data_array   = 1'b0;
    data_array_address = '0;
    data_array_data    = '0;
    write_tag_array    = 1'b0;
    unique case (state)
      IDLE: begin
        if (miss_detected) state_d = WAIT;
      end
      WAIT: begin
        fsm_busy = 1'b1;
        if (!req_done) begin
          memory_read    = 1'b1;
          memory_address = base + req_off;
        end
        write_data_array   = memory_data_valid;
        data_array_address = base + rcv_off;
        data_array_data    = memory_data;
        if (last_word) begin
          write_tag_array = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Block base and request/receive counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base     <= '0;
      req_cnt  <= '0;
      rcv_cnt  <= '0;
      req_done <= 1'b0;
    end else if (state == IDLE) begin
      if (miss_detected) begin
        base     <= miss_address & BLK_MASK;
        req_cnt  <= '0;
        rcv_cnt  <= '0;
        req_done <= 1'b0;
      end
    end else begin
      if (!req_done) begin
        req_cnt <= req_cnt + 1'b1;
        if (req_cnt == LAST) req_done <= 1'b1;
      end
      if (memory_data_valid) rcv_cnt <= rcv_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm.
// Stimulus queues expected requests/writes; a negedge monitor checks them.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [15:0] data_array_address;
  logic [15:0] data_array_data;
  logic        write_tag_array;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        tag;
  } wr_t;

  logic [15:0] rq[$];
  wr_t         wq[$];
  int          checks = 0;
  int          errors = 0;
  int          busy_cnt = 0;

  cache_fill_fsm #(
    .WORDS_PER_BLOCK(8),
    .ADDR_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .miss_detected(miss_detected),
    .miss_address(miss_address),
    .memory_data_valid(memory_data_valid),
    .memory_data(memory_data),
    .fsm_busy(fsm_busy),
    .memory_read(memory_read),
    .memory_address(memory_address),
    .write_data_array(write_data_array),
    .data_array_address(data_array_address),
    .data_array_data(data_array_data),
    .write_tag_array(write_tag_array)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] wdata(input logic [15:0] b, input int j);
    return b ^ 16'h5A5A ^ 16'(j * 16'h0101);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT strobes
  always @(negedge clk) begin
    if (!rst) begin
      if (fsm_busy) busy_cnt++;
      else chk("idle_outputs",
               {memory_read, write_data_array, write_tag_array,
                memory_address, data_array_address}, '0);
      if (memory_read) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got %h expected none",
                   memory_address);
        end else begin
          chk("req_addr", memory_address, rq.pop_front());
        end
      end
      if (write_data_array) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %h expected none",
                   data_array_address);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", data_array_address, e.addr);
          chk("wr_data", data_array_data, e.data);
          chk("wr_tag", write_tag_array, e.tag);
        end
      end else if (write_tag_array) begin
        chk("tag_without_write", write_tag_array, 1'b0);
      end
    end
  end

  // One fill: word j valid at WAIT cycle lat + j*(1+gap)
  task automatic fill(input logic [15:0] a, input logic [15:0] b,
                      input int lat, input int gap, input bit noisy,
                      input int abort_n, input int exp_busy);
    int nw;
    int last;
    int nreq;
    nw   = (abort_n > 0) ? abort_n : 8;
    last = lat + (nw - 1) * (1 + gap);
    nreq = (last + 1 < 8) ? last + 1 : 8;
    for (int i = 0; i < nreq; i++) rq.push_back(b + 16'(2 * i));
    for (int j = 0; j < nw; j++)
      wq.push_back('{b + 16'(2 * j), wdata(b, j),
                     (abort_n == 0) && (j == 7)});
    busy_cnt      = 0;
    miss_detected = 1'b1;
    miss_address  = a;
    @(posedge clk);
    #1;
    for (int c = 0; c <= last; c++) begin
      int k;
      miss_detected = noisy;
      miss_address  = 16'h8000;
      k = c - lat;
      if (k >= 0 && (k % (1 + gap)) == 0) begin
        memory_data_valid = 1'b1;
        memory_data       = wdata(b, k / (1 + gap));
      end else begin
        memory_data_valid = 1'b0;
        memory_data       = 16'hDEAD;
      end
      @(posedge clk);
      #1;
    end
    memory_data_valid = 1'b0;
    memory_data       = 16'h0000;
    miss_detected     = 1'b0;
    if (abort_n > 0) begin
      rst = 1'b1;
      #1;
      chk("async_reset_outputs",
          {fsm_busy, memory_read, write_data_array, write_tag_array,
           memory_address, data_array_address, data_array_data}, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("busy_after_abort", fsm_busy, 1'b0);
    end else begin
      @(negedge clk);
      chk("busy_after_fill", fsm_busy, 1'b0);
      chk("busy_cycles", busy_cnt, exp_busy);
    end
    chk("req_queue_empty", rq.size(), 0);
    chk("wr_queue_empty", wq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b1;
    miss_detected     = 1'b0;
    miss_address      = 16'h0000;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {fsm_busy, memory_read, write_data_array, write_tag_array,
         memory_address, data_array_address, data_array_data}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 4-cycle latency, back-to-back returns: 12 busy cycles
    fill(16'h1234, 16'h1230, 4, 0, 1'b0, 0, 12);
    // one idle cycle between valids
    fill(16'h1234, 16'h1230, 4, 1, 1'b0, 0, 19);
    // miss at 0x8000 held high during the fill is ignored
    fill(16'h1234, 16'h1230, 4, 0, 1'b1, 0, 12);

    // valid pulses while idle must not write
    memory_data_valid = 1'b1;
    memory_data       = 16'hBEEF;
    repeat (3) begin
      @(negedge clk);
      chk("idle_valid_no_write", {write_data_array, write_tag_array}, 2'b00);
    end
    memory_data_valid = 1'b0;
    @(posedge clk);
    #1;

    // abort after 3 words, then refill from word 0
    fill(16'h1234, 16'h1230, 4, 0, 1'b0, 3, 0);
    fill(16'h2002, 16'h2000, 1, 0, 1'b0, 0, 9);
    // top of the address space: no wrap
    fill(16'hFFFA, 16'hFFF0, 2, 0, 1'b0, 0, 10);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
